// File: rtl/mac_array_engine.sv
// Multi-lane MAC: per accepted beat, sum LANES act*wgt products and accumulate over a batch.
// Result valid two edges after the last accept (counting that edge); stalls on in_valid gaps, holds result until out_ready.
module mac_array_engine #(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 20,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [CNT_W-1:0]      batch_size,
  input  logic                  signed_mode,
  input  logic [LANES*DW-1:0]   act_in,
  input  logic [LANES*DW-1:0]   wgt_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ACC_W-1:0]      out_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  overflow
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   bsize, cnt;
  logic               smode;
  logic               s1_vld;
  logic [ACC_W-1:0]   psum, psum_comb, acc, acc_sum;
  logic [ACC_W-1:0]   a_ext, w_ext;
  logic               carry, ovf_now;
  logic               start, accept, last_beat;

  assign start     = (state == IDLE) && en;
  assign accept    = (state == ACCUM) && in_valid;
  assign last_beat = accept && ((cnt + CNT_ONE) == bsize);

  // Operands are extended to ACC_W before multiplying; the truncated product is
  // then the correct two's-complement or unsigned value modulo 2^ACC_W.
  always_comb begin
    psum_comb = '0;
    a_ext     = '0;
    w_ext     = '0;
    for (int i = 0; i < LANES; i++) begin
      a_ext = {{(ACC_W-DW){smode & act_in[i*DW+DW-1]}}, act_in[i*DW +: DW]};
      w_ext = {{(ACC_W-DW){smode & wgt_in[i*DW+DW-1]}}, wgt_in[i*DW +: DW]};
      psum_comb = psum_comb + a_ext * w_ext;
    end
  end

  assign {carry, acc_sum} = {1'b0, acc} + {1'b0, psum};
  assign ovf_now = smode ? ((acc[ACC_W-1] == psum[ACC_W-1]) && (acc_sum[ACC_W-1] != acc[ACC_W-1]))
                         : carry;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (en) state_nxt = (batch_size == '0) ? DRAIN : ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = HOLD;
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      bsize    <= '0;
      smode    <= 1'b0;
      cnt      <= '0;
      s1_vld   <= 1'b0;
      psum     <= '0;
      acc      <= '0;
      overflow <= 1'b0;
    end else begin
      // s1_vld drops on any non-accept cycle so a held psum is never re-added.
      s1_vld <= accept;
      if (accept) begin
        psum <= psum_comb;
        cnt  <= cnt + CNT_ONE;
      end
      if (start) begin
        bsize    <= batch_size;
        smode    <= signed_mode;
        cnt      <= '0;
        acc      <= '0;
        overflow <= 1'b0;
      end else if (s1_vld) begin
        acc <= acc_sum;
        if (ovf_now) overflow <= 1'b1;
      end
    end
  end

  assign out_sum = acc;

endmodule

// File: tb/tb_mac_array_engine.sv
`timescale 1ns/1ps
module tb_mac_array_engine;

  logic        clk = 1'b0;
  logic        nrst, en, signed_mode, in_valid, out_ready;
  logic [7:0]  batch_size;
  logic [31:0] act_in, wgt_in;
  logic        in_ready, out_valid, busy, overflow;
  logic [19:0] out_sum;

  int vectors = 0;
  int miscompares = 0;

  bit         chk_en = 1'b0;
  bit         exp_busy = 1'b0;
  bit         exp_hold = 1'b0;
  bit         exp_ovf = 1'b0;
  logic [19:0] exp_sum = '0;

  always #5 clk = ~clk;

  mac_array_engine #(.LANES(4), .DW(8), .ACC_W(20), .CNT_W(8)) dut (
    .clk(clk), .nrst(nrst), .en(en), .batch_size(batch_size),
    .signed_mode(signed_mode), .act_in(act_in), .wgt_in(wgt_in),
    .in_valid(in_valid), .in_ready(in_ready), .out_sum(out_sum),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .overflow(overflow)
  );

  task automatic chk(input string name, input longint got, input longint want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Reference model: plain integer arithmetic on the lane values.
  function automatic longint beat_psum(input logic [31:0] a, input logic [31:0] w, input bit sm);
    longint s = 0;
    longint x, y;
    for (int i = 0; i < 4; i++) begin
      x = sm ? longint'($signed(a[i*8 +: 8])) : longint'(a[i*8 +: 8]);
      y = sm ? longint'($signed(w[i*8 +: 8])) : longint'(w[i*8 +: 8]);
      s += x * y;
    end
    return s;
  endfunction

  function automatic longint sx20(input longint v);
    return (v >= 524288) ? v - 1048576 : v;
  endfunction

  task automatic model_batch(input int bs, input bit sm, input logic [31:0] a, input logic [31:0] w,
                             output logic [19:0] s, output bit o);
    longint acc = 0;
    longint p, r;
    o = 1'b0;
    for (int k = 0; k < bs; k++) begin
      p = beat_psum(a, w, sm) & 64'hFFFFF;
      if (sm) begin
        r = sx20(acc) + sx20(p);
        if (r > 524287 || r < -524288) o = 1'b1;
      end else if (acc + p > 1048575) begin
        o = 1'b1;
      end
      acc = (acc + p) & 64'hFFFFF;
    end
    s = acc[19:0];
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, exp_busy);
      chk("out_valid", out_valid, exp_hold);
      if (exp_hold) begin
        chk("hold_sum", out_sum, exp_sum);
        chk("hold_overflow", overflow, exp_ovf);
        chk("hold_in_ready", in_ready, 0);
      end
    end
  end

  task automatic accept_beat(input string name);
    bit ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      $display("FAIL %s_accept_timeout: in_ready never seen, expected 1", name);
      $fatal(1, "accept timeout");
    end
  endtask

  task automatic run_batch(input string name, input int bs, input bit sm,
                           input logic [31:0] a, input logic [31:0] w,
                           input int gap, input int hold_wait, input bit poke,
                           input longint lit_sum, input int lit_ovf);
    model_batch(bs, sm, a, w, exp_sum, exp_ovf);
    en = 1'b1; batch_size = bs[7:0]; signed_mode = sm; act_in = a; wgt_in = w;
    in_valid = (gap == 0);
    @(posedge clk); #1;
    en = 1'b0; exp_busy = 1'b1;
    for (int k = 0; k < bs; k++) begin
      if (gap > 0 && k > 0) begin
        in_valid = 1'b0;
        repeat ((k % gap) + 1) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1;
      if (poke && k == 1) begin
        en = 1'b1; batch_size = bs[7:0] + 8'd3; signed_mode = !sm;
      end
      accept_beat(name);
      en = 1'b0;
    end
    in_valid = 1'b1;
    @(negedge clk);
    chk({name, "_drain_in_ready"}, in_ready, 0);
    @(posedge clk); #1;
    exp_hold = 1'b1;
    out_ready = 1'b0;
    repeat (hold_wait) begin
      @(negedge clk);
      if (poke) en = 1'b1;
    end
    @(negedge clk);
    chk({name, "_sum"}, out_sum, lit_sum);
    chk({name, "_ovf"}, overflow, lit_ovf);
    out_ready = 1'b1;
    if (poke) en = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; en = 1'b0; in_valid = 1'b0;
    exp_hold = 1'b0; exp_busy = 1'b0;
    @(negedge clk);
    chk({name, "_idle_in_ready"}, in_ready, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    nrst = 1'b0; en = 1'b0; signed_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    batch_size = '0; act_in = '0; wgt_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    nrst = 1'b1;
    chk_en = 1'b1;

    run_batch("uns3", 3, 1'b0, {4{8'd2}}, {4{8'd3}}, 0, 0, 1'b0, 72, 0);
    run_batch("sgn2", 2, 1'b1, {4{8'hFF}}, {4{8'd5}}, 0, 1, 1'b0, 'hFFFD8, 0);
    run_batch("uns2", 2, 1'b0, {4{8'hFF}}, {4{8'd5}}, 0, 1, 1'b0, 10200, 0);
    run_batch("bp4", 4, 1'b0, {8'd10, 8'd20, 8'd30, 8'd40}, {8'd1, 8'd2, 8'd3, 8'd4},
              3, 5, 1'b1, 1200, 0);
    run_batch("ovf5", 5, 1'b0, {4{8'hFF}}, {4{8'hFF}}, 0, 0, 1'b0, 251924, 1);
    run_batch("one1", 1, 1'b0, {4{8'd1}}, {4{8'd1}}, 0, 0, 1'b0, 4, 0);
    run_batch("zero", 0, 1'b0, {4{8'd9}}, {4{8'd9}}, 0, 2, 1'b0, 0, 0);
    run_batch("sovf8", 8, 1'b1, {4{8'h80}}, {4{8'h80}}, 0, 0, 1'b0, 'h80000, 1);

    // Abort a batch after two of four beats.
    en = 1'b1; batch_size = 8'd4; signed_mode = 1'b0;
    act_in = {4{8'hFF}}; wgt_in = {4{8'hFF}}; in_valid = 1'b0;
    @(posedge clk); #1;
    en = 1'b0; exp_busy = 1'b1; in_valid = 1'b1;
    accept_beat("rst_mid");
    accept_beat("rst_mid");
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1; in_valid = 1'b0; exp_busy = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_sum", out_sum, 0);
    chk("rst_mid_overflow", overflow, 0);
    chk("rst_mid_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);

    run_batch("post_rst", 2, 1'b0, {4{8'd2}}, {4{8'd3}}, 0, 0, 1'b0, 48, 0);
    run_batch("mix3", 3, 1'b1, {8'd4, 8'd3, 8'hFE, 8'd1}, {8'h80, 8'd7, 8'd9, 8'hFF},
              1, 0, 1'b0, 'hFFA06, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
